// File: rtl/mult_product_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// mult_product_accumulator_pkg
//
// Shared definitions for the product accumulator and for whatever feeds the
// Karatsuba-Ofman multiplier upstream of it.
//
// Contents:
//   state_t                     frame FSM state (IDLE / ACC)
//   *_DEF localparams           default widths used by the accumulator top
//   CTL_SOP_BIT / CTL_EOP_BIT   position of the frame flags inside ctl
//   ctl_sop / ctl_eop           extract the frame flags from a ctl word
//   ctl_make                    build a ctl word from flags plus a user tag
//
// The feeder and the accumulator must agree on the ctl layout. Keeping the
// layout and its accessors in one place stops the two sides from drifting.
// -----------------------------------------------------------------------------
package mult_product_accumulator_pkg;

  // Frame FSM: IDLE waits for a SOP beat; ACC is inside a frame.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Default datapath sizing for the prover build.
  localparam int BITS_DEF     = 512;
  localparam int ACC_BITS_DEF = 528;
  localparam int CTL_BITS_DEF = 8;
  localparam int CNT_BITS_DEF = 16;

  // ctl sideband layout: [CTL_BITS-1:2] user tag, [1] SOP, [0] EOP.
  localparam int CTL_SOP_BIT  = 1;
  localparam int CTL_EOP_BIT  = 0;
  localparam int CTL_TAG_LSB  = 2;
  localparam int CTL_TAG_BITS = CTL_BITS_DEF - CTL_TAG_LSB;

  function automatic logic ctl_sop(input logic [CTL_BITS_DEF-1:0] ctl);
    return ctl[CTL_SOP_BIT];
  endfunction

  function automatic logic ctl_eop(input logic [CTL_BITS_DEF-1:0] ctl);
    return ctl[CTL_EOP_BIT];
  endfunction

  function automatic logic [CTL_BITS_DEF-1:0] ctl_make(
    input logic                    sop,
    input logic                    eop,
    input logic [CTL_TAG_BITS-1:0] tag
  );
    logic [CTL_BITS_DEF-1:0] c;
    c                                  = '0;
    c[CTL_BITS_DEF-1:CTL_TAG_LSB]      = tag;
    c[CTL_SOP_BIT]                     = sop;
    c[CTL_EOP_BIT]                     = eop;
    return c;
  endfunction

endpackage

// File: rtl/mult_product_accumulator_if.sv
// -----------------------------------------------------------------------------
// mult_product_accumulator_if
//
// Bundles the accumulator's product input and result output.
//
// Handshake rules (both directions use the same valid/ready contract):
//   - A transfer happens on a rising clock edge where valid && ready are both 1.
//   - The producer, once it raises valid, holds valid and its payload stable
//     until the transfer happens.
//   - ready may depend combinationally on the consumer's own downstream ready;
//     valid never depends combinationally on ready.
//
// Signals (names seen from the accumulator):
//   i_dat  [BITS]      product from the multiplier
//   i_val              product valid
//   i_ctl  [CTL_BITS]  sideband: SOP/EOP flags plus user tag
//   o_rdy              accumulator can take a product (multiplier's i_rdy)
//   o_dat  [ACC_BITS]  frame sum
//   o_val              result valid
//   o_ctl  [CTL_BITS]  ctl of the frame's EOP beat
//   o_cnt  [CNT_BITS]  beats in the frame, saturating
//   o_ovf              frame sum wrapped
//   o_err              one-cycle framing-error pulse
//   i_rdy              downstream ready for the result
//
// Modports: slave = accumulator side, master = multiplier/downstream side.
// -----------------------------------------------------------------------------
interface mult_product_accumulator_if #(
  parameter int BITS     = 512,
  parameter int ACC_BITS = 528,
  parameter int CTL_BITS = 8,
  parameter int CNT_BITS = 16
);

  logic [BITS-1:0]     i_dat;
  logic                i_val;
  logic [CTL_BITS-1:0] i_ctl;
  logic                o_rdy;
  logic [ACC_BITS-1:0] o_dat;
  logic                o_val;
  logic [CTL_BITS-1:0] o_ctl;
  logic [CNT_BITS-1:0] o_cnt;
  logic                o_ovf;
  logic                o_err;
  logic                i_rdy;

  modport slave (
    input  i_dat, i_val, i_ctl, i_rdy,
    output o_rdy, o_dat, o_val, o_ctl, o_cnt, o_ovf, o_err
  );

  modport master (
    output i_dat, i_val, i_ctl, i_rdy,
    input  o_rdy, o_dat, o_val, o_ctl, o_cnt, o_ovf, o_err
  );

endinterface

// File: rtl/mult_product_accumulator.sv
// -----------------------------------------------------------------------------
// mult_product_accumulator
//
// Sums a framed stream of BITS-wide products from the Karatsuba-Ofman
// multiplier into one ACC_BITS-wide result per frame. Frames are delimited by
// SOP/EOP flags in the ctl sideband. The result sits in a single output
// register with valid/ready; while that register is blocked, o_rdy drops and
// the whole multiplier pipeline stalls behind it.
//
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset (synchronous release upstream)
//   bus       mult_product_accumulator_if.slave (product in, result out)
//   o_state   current frame FSM state, for observation only
//
// Behaviour summary:
//   - IDLE + SOP beat starts a frame (acc = beat, cnt = 1, ovf = 0); if the
//     same beat carries EOP the frame completes immediately.
//   - IDLE + non-SOP beat is dropped and flagged on o_err.
//   - ACC + non-SOP beat adds into acc; ACC + SOP beat throws the partial
//     frame away, flags o_err and restarts from that beat.
//   - An accepted EOP beat loads sum/cnt/ovf/ctl into the output register;
//     o_val rises the following cycle.
//   - The ovf flag is sticky across the frame: any carry out of the top
//     accumulator bit sets it.
//
// The ACC_BITS-wide add feeds the output register directly; it is the
// critical path of this block.
// -----------------------------------------------------------------------------
module mult_product_accumulator
  import mult_product_accumulator_pkg::*;
#(
  parameter int BITS     = BITS_DEF,
  parameter int ACC_BITS = ACC_BITS_DEF,
  parameter int CTL_BITS = CTL_BITS_DEF,
  parameter int SOP_BIT  = CTL_SOP_BIT,
  parameter int EOP_BIT  = CTL_EOP_BIT,
  parameter int CNT_BITS = CNT_BITS_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  mult_product_accumulator_if.slave     bus,
  output state_t                        o_state
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t              state_q;
  logic [ACC_BITS-1:0] acc_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                ovf_q;

  logic                out_val_q;
  logic [ACC_BITS-1:0] out_dat_q;
  logic [CTL_BITS-1:0] out_ctl_q;
  logic [CNT_BITS-1:0] out_cnt_q;
  logic                out_ovf_q;
  logic                err_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                rdy;
  logic                accept;
  logic                sop;
  logic                eop;
  logic                start;
  logic                beat_ok;
  logic                bad;
  logic                load;
  logic [ACC_BITS-1:0] dat_ext;
  logic [ACC_BITS:0]   sum;

  // Running-frame values after the current beat is taken into account.
  logic [ACC_BITS-1:0] frm_acc_d;
  logic [CNT_BITS-1:0] frm_cnt_d;
  logic                frm_ovf_d;
  state_t              state_d;

  // The output register can take a new result whenever it is empty or is
  // being drained this very cycle, which gives one result per cycle.
  assign rdy     = !out_val_q || bus.i_rdy;
  assign accept  = bus.i_val && rdy;
  assign sop     = bus.i_ctl[SOP_BIT];
  assign eop     = bus.i_ctl[EOP_BIT];

  assign dat_ext = ACC_BITS'(bus.i_dat);
  // One extra bit on the adder so the carry out can feed the ovf flag.
  assign sum     = {1'b0, acc_q} + {1'b0, dat_ext};

  always_comb begin
    // A SOP beat always opens a fresh frame, whether or not one was open.
    start   = (state_q == IDLE) || sop;
    // A non-SOP beat in IDLE has no frame to join and is thrown away.
    beat_ok = accept && (sop || (state_q == ACC));
    // Framing errors: orphan beat in IDLE, or SOP cutting a frame short.
    bad     = accept && ((state_q == IDLE) ? !sop : sop);
    load    = beat_ok && eop;
    state_d = eop ? IDLE : ACC;

    frm_acc_d = dat_ext;
    frm_cnt_d = CNT_BITS'(1);
    frm_ovf_d = 1'b0;
    if (!start) begin
      frm_acc_d = sum[ACC_BITS-1:0];
      frm_cnt_d = (&cnt_q) ? cnt_q : (cnt_q + CNT_BITS'(1));
      frm_ovf_d = ovf_q | sum[ACC_BITS];
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, accumulator and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_val_q <= 1'b0;
      out_dat_q <= '0;
      out_ctl_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // One pulse per offending beat; a stalled beat is not accepted, so it
      // cannot pulse twice.
      err_q <= bad;

      if (beat_ok) begin
        acc_q   <= frm_acc_d;
        cnt_q   <= frm_cnt_d;
        ovf_q   <= frm_ovf_d;
        state_q <= state_d;
      end

      // A load in the same cycle as a drain replaces the old result, so
      // out_val_q simply stays high.
      if (load) begin
        out_val_q <= 1'b1;
        out_dat_q <= frm_acc_d;
        out_ctl_q <= bus.i_ctl;
        out_cnt_q <= frm_cnt_d;
        out_ovf_q <= frm_ovf_d;
      end else if (out_val_q && bus.i_rdy) begin
        out_val_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.o_rdy = rdy;
  assign bus.o_val = out_val_q;
  assign bus.o_dat = out_dat_q;
  assign bus.o_ctl = out_ctl_q;
  assign bus.o_cnt = out_cnt_q;
  assign bus.o_ovf = out_ovf_q;
  assign bus.o_err = err_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mult_product_accumulator
//
// Self-checking bench for mult_product_accumulator, built with narrow widths
// (16-bit products, 16-bit accumulator, 4-bit counter) so that wrap and
// counter saturation are reachable with short frames. Expected results are
// hand-computed constants in a frame table plus a few hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mult_product_accumulator;
  import mult_product_accumulator_pkg::*;

  localparam int BITS     = 16;
  localparam int ACC_BITS = 16;
  localparam int CTL_BITS = 8;
  localparam int CNT_BITS = 4;
  localparam int RW       = ACC_BITS + CTL_BITS + CNT_BITS + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  mult_product_accumulator_if #(
    .BITS(BITS), .ACC_BITS(ACC_BITS), .CTL_BITS(CTL_BITS), .CNT_BITS(CNT_BITS)
  ) bus ();

  state_t dut_state;

  mult_product_accumulator #(
    .BITS(BITS), .ACC_BITS(ACC_BITS), .CTL_BITS(CTL_BITS),
    .SOP_BIT(CTL_SOP_BIT), .EOP_BIT(CTL_EOP_BIT), .CNT_BITS(CNT_BITS)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus),
    .o_state (dut_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int            total;
  int            bad;
  int            err_cnt;
  int            stall_cnt;
  logic [RW-1:0] exp_q[$];
  int            stamp_q[$];

  function automatic logic [RW-1:0] pack_res(
    input logic [ACC_BITS-1:0] d, input logic [CTL_BITS-1:0] c,
    input logic [CNT_BITS-1:0] n, input logic o
  );
    return {d, c, n, o};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Results are taken on the edge following a negedge where o_val && i_rdy.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [RW-1:0] e;
      logic [RW-1:0] a;
      if (bus.o_err) err_cnt++;
      if (bus.o_val && bus.i_rdy) begin
        total++;
        a = pack_res(bus.o_dat, bus.o_ctl, bus.o_cnt, bus.o_ovf);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result: got dat=%0h ctl=%0h cnt=%0d ovf=%0b expected none",
                   bus.o_dat, bus.o_ctl, bus.o_cnt, bus.o_ovf);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL result: got dat=%0h ctl=%0h cnt=%0d ovf=%0b expected dat=%0h ctl=%0h cnt=%0d ovf=%0b",
                     a[RW-1 -: ACC_BITS], a[CTL_BITS+CNT_BITS : CNT_BITS+1], a[CNT_BITS:1], a[0],
                     e[RW-1 -: ACC_BITS], e[CTL_BITS+CNT_BITS : CNT_BITS+1], e[CNT_BITS:1], e[0]);
          end
          stamp_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic send_beat(input logic [BITS-1:0] d, input logic [CTL_BITS-1:0] c);
    bit ok;
    ok        = 1'b0;
    bus.i_dat = d;
    bus.i_ctl = c;
    bus.i_val = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.o_rdy) begin
        ok = 1'b1;
        break;
      end
      stall_cnt++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got o_rdy=0 for 64 cycles expected 1");
    end
    @(posedge clk);
    #1;
    bus.i_val = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Frame table
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int                        n;
    logic [3:0][BITS-1:0]      d;
    logic [CTL_TAG_BITS-1:0]   tag;
    logic [ACC_BITS-1:0]       exp_dat;
    logic [CNT_BITS-1:0]       exp_cnt;
    logic                      exp_ovf;
  } frame_t;

  localparam int NF = 8;
  frame_t tbl[NF];

  function automatic frame_t mk(
    input int n, input logic [BITS-1:0] d0, d1, d2, d3,
    input logic [CTL_TAG_BITS-1:0] tag,
    input logic [ACC_BITS-1:0] ed, input logic [CNT_BITS-1:0] ec, input logic eo
  );
    frame_t f;
    f.n = n; f.d = {d3, d2, d1, d0}; f.tag = tag;
    f.exp_dat = ed; f.exp_cnt = ec; f.exp_ovf = eo;
    return f;
  endfunction

  task automatic send_frame(input frame_t f);
    logic [CTL_BITS-1:0] ec;
    // The EOP beat carries SOP too when the frame is a single beat.
    ec = (f.n == 1) ? {f.tag, 2'b11} : {f.tag, 2'b01};
    exp_q.push_back(pack_res(f.exp_dat, ec, f.exp_cnt, f.exp_ovf));
    for (int i = 0; i < f.n; i++)
      send_beat(f.d[i], ctl_make(i == 0, i == f.n - 1, f.tag));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int e0;
    logic [ACC_BITS-1:0] held;

    total = 0; bad = 0; err_cnt = 0; stall_cnt = 0; cyc = 0;
    rst_n = 1'b0;
    bus.i_dat = '0; bus.i_val = 1'b0; bus.i_ctl = '0; bus.i_rdy = 1'b1;

    tbl[0] = mk(3, 16'd5,    16'd7,    16'd9,    16'd0, 6'd1, 16'd21,   4'd3, 1'b0);
    tbl[1] = mk(1, 16'd1,    16'd0,    16'd0,    16'd0, 6'd2, 16'd1,    4'd1, 1'b0);
    tbl[2] = mk(1, 16'd2,    16'd0,    16'd0,    16'd0, 6'd3, 16'd2,    4'd1, 1'b0);
    tbl[3] = mk(1, 16'd3,    16'd0,    16'd0,    16'd0, 6'd4, 16'd3,    4'd1, 1'b0);
    tbl[4] = mk(1, 16'd4,    16'd0,    16'd0,    16'd0, 6'd5, 16'd4,    4'd1, 1'b0);
    tbl[5] = mk(2, 16'hFFFF, 16'hFFFF, 16'd0,    16'd0, 6'd6, 16'hFFFE, 4'd2, 1'b1);
    tbl[6] = mk(2, 16'd1,    16'd1,    16'd0,    16'd0, 6'd7, 16'd2,    4'd2, 1'b0);
    tbl[7] = mk(4, 16'h8000, 16'h4000, 16'h4000, 16'd3, 6'd8, 16'd3,    4'd4, 1'b1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_val", 64'(bus.o_val), 64'd0);
    chk("rst_o_dat", 64'(bus.o_dat), 64'd0);
    chk("rst_o_ctl", 64'(bus.o_ctl), 64'd0);
    chk("rst_o_cnt", 64'(bus.o_cnt), 64'd0);
    chk("rst_o_ovf", 64'(bus.o_ovf), 64'd0);
    chk("rst_o_err", 64'(bus.o_err), 64'd0);
    chk("rst_o_rdy", 64'(bus.o_rdy), 64'd1);
    chk("rst_state", 64'(dut_state), 64'(IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table frames, back to back with downstream always ready
    stamp_q.delete();
    stall_cnt = 0;
    for (int i = 0; i < NF; i++) send_frame(tbl[i]);
    wait_drain();
    chk("no_stall_when_ready", 64'(stall_cnt), 64'd0);
    chk("result_count", 64'(stamp_q.size()), 64'(NF));
    if (stamp_q.size() >= 5)
      for (int i = 1; i <= 4; i++)
        chk("one_result_per_cycle", 64'(stamp_q[i] - stamp_q[i-1]), 64'd1);

    // Counter saturation: 17 beats of 1 -> sum 17, cnt stuck at 15
    exp_q.push_back(pack_res(16'd17, {6'd9, 2'b01}, 4'd15, 1'b0));
    for (int i = 0; i < 17; i++) send_beat(16'd1, ctl_make(i == 0, i == 16, 6'd9));
    wait_drain();

    // Idle gap inside a frame: 5, gap, 6 -> 11, cnt 2
    exp_q.push_back(pack_res(16'd11, {6'd10, 2'b01}, 4'd2, 1'b0));
    send_beat(16'd5, ctl_make(1'b1, 1'b0, 6'd10));
    repeat (3) @(negedge clk);
    chk("gap_state_acc", 64'(dut_state), 64'(ACC));
    @(posedge clk);
    #1;
    send_beat(16'd6, ctl_make(1'b0, 1'b1, 6'd10));
    wait_drain();

    // Result stall: downstream blocked, multiplier held off
    bus.i_rdy = 1'b0;
    exp_q.push_back(pack_res(16'h0055, {6'd11, 2'b11}, 4'd1, 1'b0));
    send_beat(16'h0055, ctl_make(1'b1, 1'b1, 6'd11));
    exp_q.push_back(pack_res(16'h0066, {6'd12, 2'b11}, 4'd1, 1'b0));
    bus.i_dat = 16'h0066;
    bus.i_ctl = ctl_make(1'b1, 1'b1, 6'd12);
    bus.i_val = 1'b1;
    held = 16'h0055;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_o_val", 64'(bus.o_val), 64'd1);
      chk("stall_o_rdy", 64'(bus.o_rdy), 64'd0);
      chk("stall_o_dat", 64'(bus.o_dat), 64'(held));
    end
    @(posedge clk);
    #1;
    bus.i_rdy = 1'b1;
    @(negedge clk);
    chk("release_o_rdy", 64'(bus.o_rdy), 64'd1);
    @(posedge clk);
    #1;
    bus.i_val = 1'b0;
    @(negedge clk);
    chk("replace_o_val", 64'(bus.o_val), 64'd1);
    chk("replace_o_dat", 64'(bus.o_dat), 64'h0066);
    @(posedge clk);
    #1;
    wait_drain();

    // Orphan beats in IDLE: both dropped, one error pulse each
    e0 = err_cnt;
    send_beat(16'd7, ctl_make(1'b0, 1'b0, 6'd13));
    send_beat(16'd8, ctl_make(1'b0, 1'b1, 6'd13));
    repeat (3) @(negedge clk);
    chk("orphan_err_pulses", 64'(err_cnt - e0), 64'd2);
    chk("orphan_state", 64'(dut_state), 64'(IDLE));
    @(posedge clk);
    #1;

    // SOP mid-frame: 10, 20 discarded, frame restarts at 3, EOP 3 -> 6
    e0 = err_cnt;
    exp_q.push_back(pack_res(16'd6, {6'd14, 2'b01}, 4'd2, 1'b0));
    send_beat(16'd10, ctl_make(1'b1, 1'b0, 6'd14));
    send_beat(16'd20, ctl_make(1'b0, 1'b0, 6'd14));
    send_beat(16'd3,  ctl_make(1'b1, 1'b0, 6'd14));
    send_beat(16'd3,  ctl_make(1'b0, 1'b1, 6'd14));
    wait_drain();
    repeat (2) @(negedge clk);
    chk("resync_err_pulse", 64'(err_cnt - e0), 64'd1);
    @(posedge clk);
    #1;

    // Reset mid-frame: partial sum discarded, next frame 4 + 6 = 10
    send_beat(16'd100, ctl_make(1'b1, 1'b0, 6'd15));
    send_beat(16'd200, ctl_make(1'b0, 1'b0, 6'd15));
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_o_val", 64'(bus.o_val), 64'd0);
    chk("midrst_o_rdy", 64'(bus.o_rdy), 64'd1);
    chk("midrst_state", 64'(dut_state), 64'(IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(pack_res(16'd10, {6'd16, 2'b01}, 4'd2, 1'b0));
    send_beat(16'd4, ctl_make(1'b1, 1'b0, 6'd16));
    send_beat(16'd6, ctl_make(1'b0, 1'b1, 6'd16));
    wait_drain();
    repeat (4) @(negedge clk);
    chk("final_o_val", 64'(bus.o_val), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_product_accumulator.md
Name: mult_product_accumulator

Overview:
- Downstream consumer of the Karatsuba-Ofman multiplier. Sums a framed sequence of BITS-wide products into one ACC_BITS-wide result (dot-product / bucket-sum stage of the prover datapath).
- Frame boundaries travel in the multiplier's ctl sideband. Emits one result per frame on a valid/ready output.
- Drives the multiplier's i_rdy from its own o_rdy, so the whole multiplier pipeline stalls when the result register is blocked.

Parameters:
- BITS, 512, width of each incoming product (the multiplier's 2x operand width).
- ACC_BITS, 528, accumulator width; ACC_BITS >= BITS; extra bits are guard bits.
- CTL_BITS, 8, sideband width, matching the multiplier.
- SOP_BIT, 1, index in i_ctl flagging the first beat of a frame.
- EOP_BIT, 0, index in i_ctl flagging the last beat of a frame.
- CNT_BITS, 16, beat-counter width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_dat  in  BITS  product from the multiplier
- i_val  in  1  product valid
- i_ctl  in  CTL_BITS  sideband, carrying SOP/EOP flags plus user tag
- o_rdy  out  1  ready to accept; drives the multiplier's i_rdy
- o_dat  out  ACC_BITS  frame sum
- o_val  out  1  result valid
- o_ctl  out  CTL_BITS  i_ctl of the EOP beat
- o_cnt  out  CNT_BITS  beats in the frame, saturating
- o_ovf  out  1  sum wrapped at 2^ACC_BITS during the frame
- o_err  out  1  one-cycle pulse on a framing error
- i_rdy  in  1  downstream ready

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; acc, cnt and ovf flag cleared.
  - o_val=0, o_dat=0, o_ctl=0, o_cnt=0, o_ovf=0, o_err=0.
  - o_rdy=1 immediately after reset.
- Reset mid-frame discards the partial sum; no result is emitted.
- Handshake:
  - o_rdy = !o_val || i_rdy (combinational).
  - A beat is accepted when i_val && o_rdy.
  - o_val/o_dat/o_ctl/o_cnt/o_ovf hold while o_val && !i_rdy.
  - o_val clears the cycle after o_val && i_rdy, unless a new result loads in that same cycle.
- Arithmetic: sum = acc + zero-extended i_dat, modulo 2^ACC_BITS. Carry out of bit ACC_BITS-1 sets the frame's sticky ovf flag.
- State IDLE:
  - Accepted beat with SOP: acc=i_dat, cnt=1, ovf=0. Go to ACC, or emit directly if EOP is also set.
  - Accepted beat without SOP: dropped, o_err pulses, stay IDLE.
- State ACC:
  - Accepted beat without SOP: acc=sum, cnt+=1 (saturates at 2^CNT_BITS-1).
  - Accepted beat with SOP: partial frame discarded, o_err pulses, new frame starts from this beat.
  - Accepted beat with EOP: final sum, cnt and ovf load the output register; return to IDLE.
- Latency: EOP beat accepted in cycle N gives o_val=1 in cycle N+1.
- Back-to-back: a single-beat frame (SOP&EOP) may be accepted every cycle while i_rdy=1; throughput is one result per cycle.
- Simultaneous output drain and EOP load in one cycle: the new result replaces the old; o_val stays 1.
- i_val=0 cycles inside a frame are idle: acc holds, cnt does not increment.
- o_err is registered. At most one pulse per offending beat.

Decomposition:
- Shared package: state enum {IDLE, ACC}, and an accessor for the SOP_BIT/EOP_BIT ctl layout so the multiplier's feeder uses the same layout.
- No sub-module. The adder, counter and output register are inline; the single-cycle ACC_BITS add is the timing-critical path and is constrained at top level.

Test Plan:
- Frame of 3 beats (SOP=5, 7, EOP=9), i_rdy=1 -> one o_val pulse, o_dat=21, o_cnt=3, o_ovf=0, o_ctl equals the EOP beat's ctl.
- Single-beat frames (SOP&EOP) with values 1,2,3,4 on consecutive cycles, i_rdy=1 -> o_dat 1,2,3,4 on consecutive cycles; o_rdy never drops.
- Two beats of 2^BITS-1 with ACC_BITS=BITS -> o_dat=2^BITS-2, o_ovf=1. Next frame 1+1 -> o_dat=2, o_ovf=0.
- Result pending with i_rdy=0 for 5 cycles -> o_rdy=0, multiplier stalled, o_dat held stable. On i_rdy=1, o_rdy returns the same cycle.
- Non-SOP beat in IDLE -> dropped, o_err pulses 1 cycle. SOP mid-frame after 10, 20 then EOP=3 -> o_err pulse, o_dat=3 (SOP beat value) + 3 or as framed.
- i_rst_n low mid-frame, then frame 4, EOP=6 -> no stale output; o_dat=10, o_cnt=2.
